// File: rtl/programmable_seq_detector_if.sv
// Bundles the serial stream, pattern control and match outputs of the
// programmable sequence detector. The bit source and control logic use the master modport; the detector uses slave.
interface programmable_seq_detector_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               i_seq;
    logic               i_seq_valid;
    logic [PAT_LEN-1:0] i_pattern;
    logic               i_load;
    logic               i_overlap;
    logic               i_clear_cnt;
    logic               o_detected;
    logic [CNT_W-1:0]   o_match_count;

    modport master (
        output i_seq, i_seq_valid, i_pattern, i_load, i_overlap, i_clear_cnt,
        input  o_detected, o_match_count
    );

    modport slave (
        input  i_seq, i_seq_valid, i_pattern, i_load, i_overlap, i_clear_cnt,
        output o_detected, o_match_count
    );
endinterface

// File: rtl/programmable_seq_detector.sv
// Serial detector for a runtime-loadable PAT_LEN-bit pattern with overlapping or
// non-overlapping matching, a registered match strobe and a saturating match counter.
module programmable_seq_detector #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    programmable_seq_detector_if.slave  if_bus
);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] r_pat;
    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_detected;
    logic [CNT_W-1:0]   r_count;

    logic [PAT_LEN-1:0] w_hist_n;
    logic [FILL_W-1:0]  w_fill_n;
    logic               w_accept;
    logic               w_match;

    // A bit only counts toward a match once PAT_LEN bits have arrived since the last flush.
    always_comb begin
        w_hist_n = {r_hist[PAT_LEN-2:0], if_bus.i_seq};
        w_fill_n = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
        w_accept = if_bus.i_seq_valid && !if_bus.i_load;
        w_match  = w_accept && (w_fill_n == FILL_FULL) && (w_hist_n == r_pat);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pat      <= '0;
            r_hist     <= '0;
            r_fill     <= '0;
            r_detected <= 1'b0;
        end else if (if_bus.i_load) begin
            r_pat      <= if_bus.i_pattern;
            r_hist     <= '0;
            r_fill     <= '0;
            r_detected <= 1'b0;
        end else if (if_bus.i_seq_valid) begin
            r_detected <= w_match;
            // Non-overlapping mode flushes the history so the next match needs fresh bits.
            if (w_match && !if_bus.i_overlap) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_hist_n;
                r_fill <= w_fill_n;
            end
        end else begin
            r_detected <= 1'b0;
        end
    end

    // Clearing wins over a same-cycle increment and ignores load.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (if_bus.i_clear_cnt) begin
            r_count <= '0;
        end else if (w_match && !(&r_count)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign if_bus.o_detected    = r_detected;
    assign if_bus.o_match_count = r_count;
endmodule
